bcd2bin_seq: RTL and testbench
==============================

BCD2BIN_SEQ -- requirements
Module: bcd2bin_seq

Interface
REQ-001 Parameters: none; all widths SHALL be fixed as listed.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  conversion request; sampled only in IDLE.
REQ-005 cen  input  4  hundreds BCD digit; sampled on the accepted start edge.
REQ-006 dez  input  4  tens BCD digit; sampled on the accepted start edge.
REQ-007 und  input  4  units BCD digit; sampled on the accepted start edge.
REQ-008 bin  output  8  binary result; registered and held until the next accepted start.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle pulse, high only in DONE.
REQ-011 ovf  output  1  result above 255; registered, held with bin.
REQ-012 err  output  1  at least one input digit above 9; registered, held with bin.

Function
REQ-013 FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-014 IDLE with start=1 at an edge: latch the 12-bit BCD word and clear the 10-bit shift accumulator and the 4-bit iteration counter; if all digits are 0-9, go to SHIFT, otherwise go to DONE with err=1, bin=0, ovf=0.
REQ-015 IDLE with start=0: remain in IDLE; outputs hold.
REQ-016 SHIFT SHALL apply one reverse double-dabble step per cycle: shift the 22-bit {BCD, accumulator} right by 1, then subtract 3 from every BCD digit that is >= 8.
REQ-017 SHIFT SHALL run exactly 10 iterations, then go to DONE.
REQ-018 On the SHIFT-to-DONE edge, the block SHALL load the 10-bit result into the output logic, set ovf = (result > 255), and set err=0.
REQ-019 Latency: for a valid input, done SHALL be high in the 11th cycle after the start edge; for an invalid input, done SHALL be high in the 1st cycle after the start edge.
REQ-020 DONE SHALL return to IDLE unconditionally after one cycle.
REQ-021 start SHALL be ignored in SHIFT and DONE, with no queuing; cen, dez and und changes SHALL have no effect after capture.
REQ-022 Results SHALL be bit-exact for all inputs 000-999; no digit combination SHALL cause an X or a hang.
REQ-023 bin, ovf and err SHALL change only on the DONE-entry edge or on reset.

Reset
REQ-024 rst_n=0 SHALL immediately force state to IDLE, and SHALL clear busy, done, bin, ovf, err, the counter and all internal registers, regardless of clk.
REQ-025 Reset during SHIFT SHALL abort the conversion, with no done pulse after release.
REQ-026 After rst_n rises, the first start SHALL be accepted on the first clk edge at which start=1.

Configuration
REQ-027 Macro BCD2BIN_SAT_EN defined: on ovf=1, bin SHALL equal 8'hFF (saturation).
REQ-028 Macro BCD2BIN_SAT_EN undefined: on ovf=1, bin SHALL equal result[7:0] (wrap); ovf SHALL be asserted identically in both builds.

Verification
REQ-029 Input cen=1, dez=2, und=3, start for 1 cycle -> busy for 11 cycles, done pulse in cycle 11, bin=8'h7B, ovf=0, err=0.
REQ-030 Input 2/5/5 -> bin=8'hFF, ovf=0; input 0/0/0 -> bin=8'h00, ovf=0; input 9/9/9 -> ovf=1, bin=8'hFF with BCD2BIN_SAT_EN, 8'hE7 without.
REQ-031 Input 2/5/6 -> ovf=1; bin=8'hFF (SAT) or 8'h00 (no SAT).
REQ-032 Input und=4'hA, start -> done in cycle 1, err=1, bin=0, busy low from cycle 2.
REQ-033 Start 1/2/3, pull rst_n low at SHIFT iteration 5 -> all outputs 0 at once; release rst_n -> no done pulse; a new start of 0/4/2 -> bin=8'h2A.
REQ-034 Start 0/1/0, re-assert start with 3/3/3 during SHIFT and DONE -> single done pulse, bin=8'h0A; the next start in IDLE is accepted.

Source files
------------

// File: rtl/bcd2bin_if.sv
// Request/result bundle for the sequential three-digit BCD to binary converter.
// Valid/ready contract: the master raises start with cen/dez/und stable; the slave takes them on
// the first rising edge where it is idle (busy=0). bin/ovf/err are valid from the cycle done pulses
// and are held until the next accepted start.
interface bcd2bin_if;
    logic       start;
    logic [3:0] cen;
    logic [3:0] dez;
    logic [3:0] und;
    logic [7:0] bin;
    logic       busy;
    logic       done;
    logic       ovf;
    logic       err;
    logic [1:0] dbg_state;

    modport master (
        output start, cen, dez, und,
        input  bin, busy, done, ovf, err, dbg_state
    );

    modport slave (
        input  start, cen, dez, und,
        output bin, busy, done, ovf, err, dbg_state
    );
endinterface

// File: rtl/bcd2bin_seq.sv
// Sequential BCD (000-999) to 8-bit binary converter using reverse double-dabble, one step per cycle.
// Define BCD2BIN_SAT_EN to saturate bin to 8'hFF on overflow; otherwise bin wraps to result[7:0].
module bcd2bin_seq (
    input  logic        clk,
    input  logic        rst_n,
    bcd2bin_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [11:0] bcd_q;
    logic [9:0]  acc_q;
    logic [3:0]  cnt_q;
    logic [7:0]  bin_q;
    logic        ovf_q;
    logic        err_q;

    logic [21:0] shifted;
    logic [11:0] bcd_adj;
    logic        digits_ok;
    logic        last_step;
    logic        res_ovf;
    logic [7:0]  res_bin;

    // One reverse double-dabble step: shift right, then correct any digit that picked up an 8.
    always_comb begin
        shifted = {bcd_q, acc_q} >> 1;
        bcd_adj = shifted[21:10];
        for (int i = 0; i < 3; i++) begin
            if (shifted[10 + 4*i +: 4] >= 4'd8)
                bcd_adj[4*i +: 4] = shifted[10 + 4*i +: 4] - 4'd3;
        end
    end

    assign digits_ok = (bus.cen <= 4'd9) && (bus.dez <= 4'd9) && (bus.und <= 4'd9);
    assign last_step = (cnt_q == 4'd9);
    assign res_ovf   = |shifted[9:8];

`ifdef BCD2BIN_SAT_EN
    assign res_bin = res_ovf ? 8'hFF : shifted[7:0];
`else
    assign res_bin = shifted[7:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.start)
                    state_nxt = digits_ok ? SHIFT : DONE;
            end
            SHIFT: begin
                if (last_step)
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_q <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            bin_q <= '0;
            ovf_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bcd_q <= {bus.cen, bus.dez, bus.und};
                        acc_q <= '0;
                        cnt_q <= '0;
                        if (!digits_ok) begin
                            bin_q <= '0;
                            ovf_q <= 1'b0;
                            err_q <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    bcd_q <= bcd_adj;
                    acc_q <= shifted[9:0];
                    cnt_q <= cnt_q + 4'd1;
                    if (last_step) begin
                        bin_q <= res_bin;
                        ovf_q <= res_ovf;
                        err_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.bin       = bin_q;
    assign bus.ovf       = ovf_q;
    assign bus.err       = err_q;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Directed bench for bcd2bin_seq: vector table through a common conversion task, plus
// hand-written reset-abort and start-during-conversion sequences.
module tb_bcd2bin_seq;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    bcd2bin_if bus ();

    bcd2bin_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] cen;
        logic [3:0] dez;
        logic [3:0] und;
        logic [7:0] exp_wrap;
        logic       exp_ovf;
        logic       exp_err;
    } vec_t;

    vec_t       vecs[13];
    logic [9:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] model(input vec_t v);
        logic [7:0] b;
        b = v.exp_wrap;
`ifdef BCD2BIN_SAT_EN
        if (v.exp_ovf) b = 8'hFF;
`endif
        return {v.exp_err, v.exp_ovf, b};
    endfunction

    // Issue one start, scramble inputs after capture, observe 14 cycles.
    task automatic run_conv(input logic [3:0] c, input logic [3:0] d, input logic [3:0] u,
                            output int lat, output int pulses, output int busy_cnt,
                            output logic [9:0] res, output logic [9:0] held);
        @(negedge clk);
        bus.cen = c; bus.dez = d; bus.und = u; bus.start = 1'b1;
        lat = 0; pulses = 0; busy_cnt = 0; res = 'x;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (i == 1) begin
                bus.start = 1'b0;
                bus.cen = 4'hF; bus.dez = 4'hF; bus.und = 4'hF;
            end
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                pulses++;
                if (lat == 0) begin
                    lat = i;
                    res = {bus.err, bus.ovf, bus.bin};
                end
            end
        end
        held = {bus.err, bus.ovf, bus.bin};
    endtask

    initial begin
        int         lat, pulses, busy_cnt;
        logic [9:0] res, held, exp;
        n_tests = 0;
        n_fail  = 0;

        vecs[0]  = '{4'd1, 4'd2, 4'd3, 8'h7B, 1'b0, 1'b0};
        vecs[1]  = '{4'd2, 4'd5, 4'd5, 8'hFF, 1'b0, 1'b0};
        vecs[2]  = '{4'd0, 4'd0, 4'd0, 8'h00, 1'b0, 1'b0};
        vecs[3]  = '{4'd9, 4'd9, 4'd9, 8'hE7, 1'b1, 1'b0};
        vecs[4]  = '{4'd2, 4'd5, 4'd6, 8'h00, 1'b1, 1'b0};
        vecs[5]  = '{4'd0, 4'd0, 4'hA, 8'h00, 1'b0, 1'b1};
        vecs[6]  = '{4'd0, 4'd0, 4'd1, 8'h01, 1'b0, 1'b0};
        vecs[7]  = '{4'd1, 4'd2, 4'd8, 8'h80, 1'b0, 1'b0};
        vecs[8]  = '{4'd0, 4'd9, 4'd9, 8'h63, 1'b0, 1'b0};
        vecs[9]  = '{4'hF, 4'd0, 4'd0, 8'h00, 1'b0, 1'b1};
        vecs[10] = '{4'd5, 4'd0, 4'd0, 8'hF4, 1'b1, 1'b0};
        vecs[11] = '{4'd3, 4'hC, 4'd7, 8'h00, 1'b0, 1'b1};
        vecs[12] = '{4'd1, 4'd0, 4'd0, 8'h64, 1'b0, 1'b0};

        // Reset block
        rst_n = 1'b0;
        bus.start = 1'b0; bus.cen = '0; bus.dez = '0; bus.und = '0;
        repeat (3) @(negedge clk);
        check("reset_out", {bus.err, bus.ovf, bus.bin, bus.busy, bus.done}, '0);
        check("reset_state", bus.dbg_state, 2'd0);
        rst_n = 1'b1;

        // Table-driven vectors
        foreach (vecs[k]) begin
            exp_q.push_back(model(vecs[k]));
            run_conv(vecs[k].cen, vecs[k].dez, vecs[k].und, lat, pulses, busy_cnt, res, held);
            exp = exp_q.pop_front();
            check($sformatf("v%0d_result", k), res, exp);
            check($sformatf("v%0d_held", k), held, exp);
            check($sformatf("v%0d_latency", k), lat, vecs[k].exp_err ? 1 : 11);
            check($sformatf("v%0d_busy_cycles", k), busy_cnt, vecs[k].exp_err ? 1 : 11);
            check($sformatf("v%0d_pulses", k), pulses, 1);
        end

        // Reset in the middle of SHIFT aborts and clears everything at once
        @(negedge clk);
        bus.cen = 4'd1; bus.dez = 4'd2; bus.und = 4'd3; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_shift_busy", bus.busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_out", {bus.err, bus.ovf, bus.bin, bus.busy, bus.done}, '0);
        check("abort_state", bus.dbg_state, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) pulses++;
        end
        check("abort_no_done", pulses, 0);
        run_conv(4'd0, 4'd4, 4'd2, lat, pulses, busy_cnt, res, held);
        check("after_abort_result", res, 10'h02A);
        check("after_abort_latency", lat, 11);

        // start re-asserted with other digits during SHIFT and DONE is ignored
        @(negedge clk);
        bus.cen = 4'd0; bus.dez = 4'd1; bus.und = 4'd0; bus.start = 1'b1;
        @(negedge clk);
        bus.cen = 4'd3; bus.dez = 4'd3; bus.und = 4'd3;
        pulses = 0; lat = 0; res = 'x;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            if (i > 1) @(negedge clk);
            if (bus.done) begin
                pulses++;
                lat = i;
                res = {bus.err, bus.ovf, bus.bin};
                bus.start = 1'b0;
            end
        end
        check("reassert_latency", lat, 11);
        check("reassert_result", res, 10'h00A);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.done) pulses++;
        end
        check("reassert_pulses", pulses, 1);
`ifdef BCD2BIN_SAT_EN
        exp = 10'h1FF;
`else
        exp = 10'h14D;
`endif
        run_conv(4'd3, 4'd3, 4'd3, lat, pulses, busy_cnt, res, held);
        check("next_start_result", res, exp);
        check("next_start_latency", lat, 11);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
